// File: rtl/aes_decipher.sv
// Iterative AES-128 inverse cipher: forward key expansion, then one decryption round per clock.
// Optional macro AES_KEY_CACHE_EN keeps the last expanded key so a repeated key skips expansion.
module aes_decipher (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] datain,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] dataout
);

  typedef enum logic [2:0] {IDLE, KEYEXP, INIT, ROUND, DONE} state_e;

  state_e       state_q;
  logic [3:0]   cnt_q;
  logic [127:0] blk_q;
  logic [127:0] rk_q [0:10];
  logic         out_valid_q;
  logic [127:0] dataout_q;
`ifdef AES_KEY_CACHE_EN
  logic [127:0] tag_q;
  logic         tag_vld_q;
`endif

  logic [127:0] rk_d;
  logic [127:0] blk_d;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240;
    x2   = gmul(x, x);
    x3   = gmul(x2, x);
    x6   = gmul(x3, x3);
    x12  = gmul(x6, x6);
    x15  = gmul(x12, x3);
    x30  = gmul(x15, x15);
    x60  = gmul(x30, x30);
    x120 = gmul(x60, x60);
    x240 = gmul(x120, x120);
    return gmul(gmul(x240, x12), x2);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] next_rk(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Byte n of a block sits at [127-8n -: 8]; bytes are column-major (row + 4*col).
  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic mix);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [127:0] r;
    for (int col = 0; col < 4; col++)
      for (int row = 0; row < 4; row++)
        a[row + 4*col] = inv_sbox(s[127 - 8*(row + 4*((col - row + 4) % 4)) -: 8])
                         ^ rk[127 - 8*(row + 4*col) -: 8];
    for (int col = 0; col < 4; col++) begin
      b[4*col+0] = gmul(8'h0e, a[4*col]) ^ gmul(8'h0b, a[4*col+1]) ^ gmul(8'h0d, a[4*col+2]) ^ gmul(8'h09, a[4*col+3]);
      b[4*col+1] = gmul(8'h09, a[4*col]) ^ gmul(8'h0e, a[4*col+1]) ^ gmul(8'h0b, a[4*col+2]) ^ gmul(8'h0d, a[4*col+3]);
      b[4*col+2] = gmul(8'h0d, a[4*col]) ^ gmul(8'h09, a[4*col+1]) ^ gmul(8'h0e, a[4*col+2]) ^ gmul(8'h0b, a[4*col+3]);
      b[4*col+3] = gmul(8'h0b, a[4*col]) ^ gmul(8'h0d, a[4*col+1]) ^ gmul(8'h09, a[4*col+2]) ^ gmul(8'h0e, a[4*col+3]);
    end
    r = '0;
    for (int n = 0; n < 16; n++)
      r[127 - 8*n -: 8] = mix ? b[n] : a[n];
    return r;
  endfunction

  // cnt_q is the index of the source key during KEYEXP and the round key during ROUND.
  always_comb begin
    rk_d  = next_rk(rk_q[cnt_q], rcon(cnt_q));
    blk_d = inv_round(blk_q, rk_q[cnt_q], cnt_q != 4'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      blk_q       <= '0;
      out_valid_q <= 1'b0;
      dataout_q   <= '0;
      // NOTE: the round-key store is flops, not RAM, so clearing it in reset is legal and required.
      for (int i = 0; i < 11; i++) rk_q[i] <= '0;
`ifdef AES_KEY_CACHE_EN
      tag_q     <= '0;
      tag_vld_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            blk_q <= datain;
            cnt_q <= 4'd0;
`ifdef AES_KEY_CACHE_EN
            if (tag_vld_q && key == tag_q) begin
              state_q <= INIT;
            end else begin
              rk_q[0]   <= key;
              tag_q     <= key;
              tag_vld_q <= 1'b1;
              state_q   <= KEYEXP;
            end
`else
            rk_q[0] <= key;
            state_q <= KEYEXP;
`endif
          end
        end
        KEYEXP: begin
          rk_q[cnt_q + 4'd1] <= rk_d;
          if (cnt_q == 4'd9) state_q <= INIT;
          else               cnt_q   <= cnt_q + 4'd1;
        end
        INIT: begin
          blk_q   <= blk_q ^ rk_q[10];
          cnt_q   <= 4'd9;
          state_q <= ROUND;
        end
        ROUND: begin
          blk_q <= blk_d;
          if (cnt_q == 4'd0) begin
            out_valid_q <= 1'b1;
            dataout_q   <= blk_d;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            dataout_q   <= '0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign dataout   = dataout_q;

endmodule

// File: tb/tb_aes_decipher.sv
// Self-checking bench: a behavioural AES-128 encryptor builds ciphertexts, the DUT must recover the plaintext.
// Expected latency follows AES_KEY_CACHE_EN (11 edges on a cached key, else 21).
module tb_aes_decipher;

`ifdef AES_KEY_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] datain;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] dataout;

  aes_decipher dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .datain    (datain),
    .key       (key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dataout   (dataout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]   sb [256];
  logic [127:0] m_tag;
  bit           m_tag_vld = 1'b0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= t;
      t = xt(t);
    end
    return p;
  endfunction

  // Forward S-box from its definition: brute-force inverse, then the affine map.
  task automatic build_sbox();
    logic [7:0] inv, b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sb[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  task automatic encrypt(input logic [127:0] pt, input logic [127:0] k, output logic [127:0] ct);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  r, a0, a1, a2, a3;
    logic [7:0]  s [16];
    logic [7:0]  u [16];
    r = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {r, 24'h0};
        r = xt(r);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int n = 0; n < 16; n++) s[n] = pt[127 - 8*n -: 8] ^ w[n/4][31 - 8*(n%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          u[row + 4*c] = sb[s[row + 4*((c + row) % 4)]];
      for (int c = 0; c < 4; c++) begin
        a0 = u[4*c]; a1 = u[4*c+1]; a2 = u[4*c+2]; a3 = u[4*c+3];
        if (rnd < 10) begin
          u[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          u[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          u[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          u[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int n = 0; n < 16; n++) s[n] = u[n] ^ w[4*rnd + n/4][31 - 8*(n%4) -: 8];
    end
    for (int n = 0; n < 16; n++) ct[127 - 8*n -: 8] = s[n];
  endtask

  // One request: accept, latency, hold under backpressure, then release (or reset while DONE).
  task automatic do_req(input string tag, input logic [127:0] k, input logic [127:0] ct,
                        input logic [127:0] pt, input int hold, input bit eager,
                        input int busy_at, input bit rst_in_done);
    int exp_lat;
    int lat;
    exp_lat = (CACHE && m_tag_vld && k == m_tag) ? 11 : 21;
    @(negedge clk);
    check({tag, ":ready"}, in_ready, 1);
    in_valid = 1'b1; datain = ct; key = k; out_ready = eager;
    @(posedge clk);
    m_tag = k; m_tag_vld = 1'b1;
    #1;
    in_valid = 1'b0; datain = {$urandom, $urandom, $urandom, $urandom}; key = ~k;
    check({tag, ":busy"}, in_ready, 0);
    lat = 0;
    for (int e = 1; e <= 40 && lat == 0; e++) begin
      @(posedge clk); #1;
      if (out_valid) lat = e;
      else in_valid = (e == busy_at);
    end
    in_valid = 1'b0;
    check({tag, ":latency"}, lat, exp_lat);
    check({tag, ":plaintext"}, dataout, pt);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, ":hold_data"}, dataout, pt);
      check({tag, ":hold_flags"}, {out_valid, in_ready}, 2'b10);
    end
    if (rst_in_done) begin
      #2 rst_n = 1'b0;
      #1;
      check({tag, ":rst_flags"}, {out_valid, in_ready}, 2'b01);
      check({tag, ":rst_data"}, dataout, 0);
      @(negedge clk);
      rst_n = 1'b1; m_tag_vld = 1'b0;
    end else begin
      if (!eager) begin
        @(negedge clk);
        out_ready = 1'b1;
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, ":release_flags"}, {out_valid, in_ready}, 2'b01);
      check({tag, ":release_data"}, dataout, 0);
    end
  endtask

  task automatic abort_req(input logic [127:0] k, input logic [127:0] ct);
    @(negedge clk);
    check("abort:ready", in_ready, 1);
    in_valid = 1'b1; datain = ct; key = k; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort:flags", {out_valid, in_ready}, 2'b01);
    check("abort:data", dataout, 0);
    @(negedge clk);
    rst_n = 1'b1; m_tag_vld = 1'b0;
  endtask

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] RT_KEY = 128'h30313032303330343035303630373038;
  localparam logic [127:0] RT_PT  = 128'h31323334353637383132333435363738;

  initial begin
    logic [127:0] ct, k, pt;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; datain = '0; key = '0;
    build_sbox();
    #12;
    check("reset:flags", {out_valid, in_ready}, 2'b01);
    check("reset:data", dataout, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_req("c1", C1_KEY, C1_CT, C1_PT, 0, 1'b0, 0, 1'b0);
    do_req("c1_again", C1_KEY, C1_CT, C1_PT, 0, 1'b0, 0, 1'b0);
    encrypt(RT_PT, RT_KEY, ct);
    do_req("roundtrip", RT_KEY, ct, RT_PT, 0, 1'b0, 0, 1'b0);
    do_req("backpressure", RT_KEY, ct, RT_PT, 5, 1'b0, 0, 1'b0);
    do_req("busy_req", C1_KEY, C1_CT, C1_PT, 0, 1'b0, 5, 1'b0);
    abort_req(C1_KEY, C1_CT);
    do_req("after_abort", C1_KEY, C1_CT, C1_PT, 0, 1'b0, 0, 1'b0);
    do_req("cache_hit", C1_KEY, C1_CT, C1_PT, 0, 1'b0, 0, 1'b0);
    do_req("key_change", RT_KEY, ct, RT_PT, 0, 1'b0, 0, 1'b0);

    k = RT_KEY;
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 2) != 0) k = {$urandom, $urandom, $urandom, $urandom};
      pt = {$urandom, $urandom, $urandom, $urandom};
      encrypt(pt, k, ct);
      if ($urandom_range(0, 1) == 1)
        do_req("rand_eager", k, ct, pt, 0, 1'b1, 0, 1'b0);
      else
        do_req("rand_hold", k, ct, pt, $urandom_range(0, 3), 1'b0, $urandom_range(0, 12), i == 5);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time budget, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/aes_decipher.md
AES_DECIPHER -- requirements
Module: aesdecipher

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL: in_valid  input  1  request holds valid ciphertext and key.
REQ-004 SHALL: in_ready  output  1  block can accept a request.
REQ-005 SHALL: datain  input  128  ciphertext, byte 0 in bits [127:120].
REQ-006 SHALL: key  input  128  AES-128 cipher key, same byte order.
REQ-007 SHALL: out_valid  output  1  dataout holds recovered plaintext.
REQ-008 SHALL: out_ready  input  1  consumer accepts dataout.
REQ-009 SHALL: dataout  output  128  plaintext, same byte order.

Function
REQ-010 SHALL: implement the FIPS-197 AES-128 inverse cipher iteratively, one round per cycle; exact inverse of aescipher.
REQ-011 SHALL: FSM states IDLE, KEYEXP, INIT, ROUND, DONE.
REQ-012 SHALL: in_ready = 1 only in IDLE; request accepted on an edge with in_valid && in_ready; datain and key registered only at that edge.
REQ-013 SHALL: IDLE -> KEYEXP on accept; rk0 = key.
REQ-014 SHALL: KEYEXP, 10 cycles, computes rk1..rk10 forward (RotWord, SubWord, Rcon 01,02,04,08,10,20,40,80,1b,36) and stores all 11 round keys.
REQ-015 SHALL: INIT, 1 cycle: state = ciphertext XOR rk10.
REQ-016 SHALL: ROUND, 10 cycles, round index 9 down to 0: InvShiftRows, InvSubBytes, XOR rk[index], then InvMixColumns only when index != 0.
REQ-017 SHALL: ROUND -> DONE after index 0; out_valid rises on the 21st edge after the accept edge.
REQ-018 SHALL: InvSubBytes use 16 inverse S-box lookups; key expansion uses 4 forward S-box lookups; InvMixColumns uses GF(2^8) multiply by 09/0b/0d/0e with modulus 0x11b.
REQ-019 SHALL: in DONE, hold out_valid = 1 and dataout stable until out_ready = 1; on that edge go to IDLE and clear out_valid.
REQ-020 SHALL: in_valid asserted outside IDLE is ignored, with no side effects; out_ready while out_valid = 0 is ignored.
REQ-021 SHALL: dataout be 128'h0 whenever out_valid = 0.

Reset
REQ-022 SHALL: on rst_n low, immediately force IDLE, out_valid = 0, dataout = 0, round counter = 0, round-key store and key tag cleared, cache-valid flag cleared.
REQ-023 SHALL: reset asserted mid-operation abort the operation with no output; the first request after reset deasserts runs full latency.
REQ-024 SHALL: in_ready = 1 on the first edge after reset deasserts.

Configuration
REQ-025 SHALL: macro AES_KEY_CACHE_EN, when defined, keep the last expanded key as a tag with a valid flag; a request whose key equals a valid tag skips KEYEXP (IDLE -> INIT), so out_valid rises on the 11th edge after accept.
REQ-026 SHALL: when AES_KEY_CACHE_EN is defined and the key differs from the tag, take the full KEYEXP path and update the tag.
REQ-027 SHALL: when AES_KEY_CACHE_EN is undefined, no tag logic exists and every request takes the full KEYEXP path (21-edge latency).

Verification
REQ-028 SHALL: FIPS-197 C.1 test: key 000102030405060708090a0b0c0d0e0f, datain 69c4e0d86a7b0430d8cdb78070b4c55a -> dataout 00112233445566778899aabbccddeeff, out_valid at edge 21.
REQ-029 SHALL: round trip: key 30313032303330343035303630373038 with datain = aescipher output for plaintext 31323334353637383132333435363738 -> dataout 31323334353637383132333435363738.
REQ-030 SHALL: backpressure: out_ready held 0 for 5 cycles after out_valid -> dataout stable, in_ready = 0 throughout; out_ready = 1 -> IDLE next edge.
REQ-031 SHALL: busy request: in_valid pulsed with a different key at cycle 5 of KEYEXP -> ignored; result still matches REQ-028.
REQ-032 SHALL: reset at cycle 15 after accept -> out_valid = 0 and dataout = 0 immediately; a new REQ-028 request then completes at edge 21.
REQ-033 SHALL: with AES_KEY_CACHE_EN, two back-to-back REQ-028 requests -> second out_valid at edge 11, same plaintext; a changed key -> edge 21.
